// File: rtl/video_scaler_fetch_if.sv
// Bus bundle for the line-buffer fetch unit: CPU buffer port, video
// timing/fetch controls, scaled pixel output and FSM debug state.
//
// Fetch handshake: a pixel request is taken on a rising clk edge when
// fetch_next and fetch_ready are both high and neither next_field nor
// next_line is high that cycle. Exactly one cycle later pix_valid is high
// with pix_data. fetch_ready never depends on fetch_next.
interface video_scaler_fetch_if #(
  parameter int DATA_W     = 24,
  parameter int ADDR_WIDTH = 11,
  parameter int XW         = 9
);
  logic [ADDR_WIDTH-1:0]    cpu_addr;
  logic [DATA_W-1:0]        cpu_wdata;
  logic                     cpu_wen;
  logic [DATA_W-1:0]        cpu_rdata;
  logic                     ring_mode;
  logic [ADDR_WIDTH-XW-1:0] prod_row;
  logic                     next_field;
  logic                     next_line;
  logic                     fetch_next;
  logic                     fetch_ready;
  logic                     pix_valid;
  logic [DATA_W-1:0]        pix_data;
  logic [ADDR_WIDTH-XW-1:0] curr_src_row;
  logic                     field_done;
  logic [1:0]               state_dbg;

  modport master (
    output cpu_addr, cpu_wdata, cpu_wen, ring_mode, prod_row,
           next_field, next_line, fetch_next,
    input  cpu_rdata, fetch_ready, pix_valid, pix_data, curr_src_row,
           field_done, state_dbg
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_wen, ring_mode, prod_row,
           next_field, next_line, fetch_next,
    output cpu_rdata, fetch_ready, pix_valid, pix_data, curr_src_row,
           field_done, state_dbg
  );
endinterface

// File: rtl/video_scaler_fetch.sv
// Line-buffer fetch unit with a DDA nearest-neighbour upscaler.
// CPU port A reads/writes the buffer; the scaler reads port B at {row, x},
// stepping x and row with error accumulators instead of skip counters.
// Ring mode stalls the reader while it sits on the row the producer writes.
module video_scaler_fetch #(
  parameter int DATA_W     = 24,
  parameter int ADDR_WIDTH = 11,
  parameter int XW         = 9,
  parameter int SRC_W      = 480,
  parameter int SRC_H      = 320,
  parameter int DST_W      = 640,
  parameter int DST_H      = 480
) (
  input logic                clk,
  input logic                reset,
  video_scaler_fetch_if.slave bus
);
  localparam int RW  = ADDR_WIDTH - XW;
  localparam int XAW = $clog2(2 * DST_W) + 1;
  localparam int YAW = $clog2(2 * DST_H) + 1;
  localparam int LCW = $clog2(DST_H + 1);

  localparam logic [XAW-1:0] SRC_W_A = XAW'(SRC_W);
  localparam logic [XAW-1:0] DST_W_A = XAW'(DST_W);
  localparam logic [YAW-1:0] SRC_H_A = YAW'(SRC_H);
  localparam logic [YAW-1:0] DST_H_A = YAW'(DST_H);
  localparam logic [LCW-1:0] DST_H_L = LCW'(DST_H);
  localparam logic [XW-1:0]  X_MAX   = XW'(SRC_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [XAW-1:0]  xacc_q, xacc_d, xacc_sum;
  logic [YAW-1:0]  yacc_q, yacc_d, yacc_sum;
  logic [RW-1:0]   row_q, row_d;
  logic [LCW-1:0]  line_cnt_q, line_cnt_d, line_inc;
  logic            done_q, done_d;
  logic            ready;
  logic            fetch_ok;

  logic [DATA_W-1:0]     mem [0:(2**ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_W-1:0]     cpu_rdata_q;
  logic [DATA_W-1:0]     pix_data_q;
  logic                  pix_valid_q;

  // The reader may not enter the row the producer is still filling.
  assign ready   = (state_q == ST_ACTIVE) && !(bus.ring_mode && (row_q == bus.prod_row));
  assign rd_addr = {row_q, x_q};

  // Next-state and scaler arithmetic; next_field beats next_line beats fetch.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    xacc_d     = xacc_q;
    yacc_d     = yacc_q;
    row_d      = row_q;
    line_cnt_d = line_cnt_q;
    done_d     = 1'b0;
    fetch_ok   = 1'b0;
    xacc_sum   = xacc_q + SRC_W_A;
    yacc_sum   = yacc_q + SRC_H_A;
    line_inc   = line_cnt_q + LCW'(1);
    if (bus.next_field) begin
      state_d    = ST_ACTIVE;
      x_d        = '0;
      xacc_d     = '0;
      yacc_d     = '0;
      row_d      = '0;
      line_cnt_d = '0;
    end else if (state_q == ST_ACTIVE) begin
      if (bus.next_line) begin
        x_d    = '0;
        xacc_d = '0;
        if (yacc_sum >= DST_H_A) begin
          yacc_d = yacc_sum - DST_H_A;
          row_d  = row_q + RW'(1);
        end else begin
          yacc_d = yacc_sum;
        end
        line_cnt_d = line_inc;
        if (line_inc == DST_H_L) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end else if (bus.fetch_next && ready) begin
        fetch_ok = 1'b1;
        // SRC_W <= DST_W, so one subtraction always brings xacc back in range.
        if (xacc_sum >= DST_W_A) begin
          xacc_d = xacc_sum - DST_W_A;
          if (x_q < X_MAX) x_d = x_q + XW'(1);
        end else begin
          xacc_d = xacc_sum;
        end
      end
    end
  end

  // FSM and scaler state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      xacc_q     <= '0;
      yacc_q     <= '0;
      row_q      <= '0;
      line_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      xacc_q     <= xacc_d;
      yacc_q     <= yacc_d;
      row_q      <= row_d;
      line_cnt_q <= line_cnt_d;
      done_q     <= done_d;
    end
  end

  // CPU write port; the buffer contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (bus.cpu_wen) mem[bus.cpu_addr] <= bus.cpu_wdata;
  end

  // Registered reads on both ports; a same-cycle write is seen next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata_q <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      cpu_rdata_q <= mem[bus.cpu_addr];
      pix_valid_q <= fetch_ok;
      if (fetch_ok) pix_data_q <= mem[rd_addr];
    end
  end

  assign bus.cpu_rdata    = cpu_rdata_q;
  assign bus.fetch_ready  = ready;
  assign bus.pix_valid    = pix_valid_q;
  assign bus.pix_data     = pix_data_q;
  assign bus.curr_src_row = row_q;
  assign bus.field_done   = done_q;
  assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_video_scaler_fetch.sv
// Directed bench for video_scaler_fetch at default parameters
// (480x320 source on a 640x480 raster, 4-row ring).
module tb_video_scaler_fetch;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  video_scaler_fetch_if #(.DATA_W(24), .ADDR_WIDTH(11), .XW(9)) bus ();

  video_scaler_fetch #(
    .DATA_W(24), .ADDR_WIDTH(11), .XW(9),
    .SRC_W(480), .SRC_H(320), .DST_W(640), .DST_H(480)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer contents encode their own address so pix_data reveals the read address.
  function automatic logic [23:0] data_of(input logic [10:0] a);
    return 24'hC00000 | {13'h0, a};
  endfunction

  // Driver tasks: inputs change just after a falling edge.
  task automatic cpu_write(input logic [10:0] a, input logic [23:0] d);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_wen   = 1'b1;
    @(negedge clk);
    bus.cpu_wen   = 1'b0;
  endtask

  task automatic pulse_field();
    bus.next_field = 1'b1;
    @(negedge clk);
    bus.next_field = 1'b0;
  endtask

  task automatic pulse_line();
    bus.next_line = 1'b1;
    @(negedge clk);
    bus.next_line = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.fetch_next = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid got %b want 0", bus.pix_valid); end
    n_cmp++; if (bus.pix_data !== 24'h0) begin n_fail++; $display("FAIL reset_pix_data got %h want 0", bus.pix_data); end
    n_cmp++; if (bus.cpu_rdata !== 24'h0) begin n_fail++; $display("FAIL reset_cpu_rdata got %h want 0", bus.cpu_rdata); end
    n_cmp++; if (bus.curr_src_row !== 2'd0) begin n_fail++; $display("FAIL reset_row got %0d want 0", bus.curr_src_row); end
    n_cmp++; if (bus.field_done !== 1'b0) begin n_fail++; $display("FAIL reset_field_done got %b want 0", bus.field_done); end
    n_cmp++; if (bus.fetch_ready !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_ready got %b want 0", bus.fetch_ready); end
    n_cmp++; if (bus.state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", bus.state_dbg); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL idle_fetch_ignored got %b want 0", bus.pix_valid); end
    n_cmp++; if (bus.fetch_ready !== 1'b0) begin n_fail++; $display("FAIL idle_fetch_ready got %b want 0", bus.fetch_ready); end
    bus.fetch_next = 1'b0;
  endtask

  task automatic test_cpu_port();
    for (int r = 0; r < 4; r++)
      for (int x = 0; x < 8; x++)
        cpu_write({r[1:0], x[8:0]}, data_of({r[1:0], x[8:0]}));
    cpu_write(11'd479, data_of(11'd479));
    bus.cpu_addr = 11'h205;
    @(negedge clk);
    n_cmp++; if (bus.cpu_rdata !== data_of(11'h205)) begin n_fail++; $display("FAIL cpu_readback got %h want %h", bus.cpu_rdata, data_of(11'h205)); end
    cpu_write(11'h100, 24'h111111);
    bus.cpu_addr  = 11'h100;
    bus.cpu_wdata = 24'h222222;
    bus.cpu_wen   = 1'b1;
    @(negedge clk);
    bus.cpu_wen   = 1'b0;
    n_cmp++; if (bus.cpu_rdata !== 24'h111111) begin n_fail++; $display("FAIL cpu_read_before_write got %h want 111111", bus.cpu_rdata); end
    @(negedge clk);
    n_cmp++; if (bus.cpu_rdata !== 24'h222222) begin n_fail++; $display("FAIL cpu_read_after_write got %h want 222222", bus.cpu_rdata); end
  endtask

  task automatic test_x_sequence();
    logic [8:0] exp_x [8];
    exp_x = '{9'd0, 9'd0, 9'd1, 9'd2, 9'd3, 9'd3, 9'd4, 9'd5};
    bus.fetch_next = 1'b1;
    pulse_field();
    n_cmp++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL field_cycle_no_pixel got %b want 0", bus.pix_valid); end
    n_cmp++; if (bus.state_dbg !== 2'd1) begin n_fail++; $display("FAIL field_to_active got %0d want 1", bus.state_dbg); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.pix_valid !== 1'b1 || bus.pix_data !== data_of({2'd0, exp_x[i]})) begin
        n_fail++; $display("FAIL x_seq[%0d] got v=%b d=%h want v=1 d=%h", i, bus.pix_valid, bus.pix_data, data_of({2'd0, exp_x[i]}));
      end
    end
    bus.fetch_next = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL x_seq_idle got %b want 0", bus.pix_valid); end
  endtask

  task automatic test_rows();
    logic [1:0] exp_row [5];
    exp_row = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
    pulse_field();
    for (int i = 0; i < 5; i++) begin
      pulse_line();
      n_cmp++; if (bus.curr_src_row !== exp_row[i]) begin n_fail++; $display("FAIL row_after_line%0d got %0d want %0d", i + 1, bus.curr_src_row, exp_row[i]); end
    end
    bus.fetch_next = 1'b1;
    @(negedge clk);
    bus.fetch_next = 1'b0;
    n_cmp++; if (bus.pix_data !== data_of(11'h600)) begin n_fail++; $display("FAIL row3_first_pixel got %h want %h", bus.pix_data, data_of(11'h600)); end
    repeat (474) pulse_line();
    n_cmp++; if (bus.field_done !== 1'b0 || bus.state_dbg !== 2'd1) begin n_fail++; $display("FAIL line479_not_done got fd=%b st=%0d want fd=0 st=1", bus.field_done, bus.state_dbg); end
    pulse_line();
    n_cmp++; if (bus.field_done !== 1'b1) begin n_fail++; $display("FAIL field_done_pulse got %b want 1", bus.field_done); end
    n_cmp++; if (bus.state_dbg !== 2'd2) begin n_fail++; $display("FAIL done_state got %0d want 2", bus.state_dbg); end
    n_cmp++; if (bus.curr_src_row !== 2'd0) begin n_fail++; $display("FAIL row_after_480_lines got %0d want 0", bus.curr_src_row); end
    bus.fetch_next = 1'b1;
    #1;
    n_cmp++; if (bus.fetch_ready !== 1'b0) begin n_fail++; $display("FAIL done_fetch_ready got %b want 0", bus.fetch_ready); end
    @(negedge clk);
    n_cmp++; if (bus.field_done !== 1'b0) begin n_fail++; $display("FAIL field_done_one_cycle got %b want 0", bus.field_done); end
    n_cmp++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL done_fetch_ignored got %b want 0", bus.pix_valid); end
    bus.fetch_next = 1'b0;
    pulse_line();
    n_cmp++; if (bus.curr_src_row !== 2'd0 || bus.field_done !== 1'b0) begin n_fail++; $display("FAIL done_line_ignored got row=%0d fd=%b want row=0 fd=0", bus.curr_src_row, bus.field_done); end
  endtask

  task automatic test_ring_stall();
    bus.ring_mode = 1'b1;
    bus.prod_row  = 2'd1;
    pulse_field();
    pulse_line();
    #1;
    n_cmp++; if (bus.fetch_ready !== 1'b1) begin n_fail++; $display("FAIL ring_row0_ready got %b want 1", bus.fetch_ready); end
    pulse_line();
    bus.fetch_next = 1'b1;
    #1;
    n_cmp++; if (bus.fetch_ready !== 1'b0) begin n_fail++; $display("FAIL ring_stall_ready got %b want 0", bus.fetch_ready); end
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL ring_stall_no_pixel got %b want 0", bus.pix_valid); end
    bus.prod_row = 2'd2;
    #1;
    n_cmp++; if (bus.fetch_ready !== 1'b1) begin n_fail++; $display("FAIL ring_resume_ready got %b want 1", bus.fetch_ready); end
    @(negedge clk);
    bus.fetch_next = 1'b0;
    n_cmp++; if (bus.pix_valid !== 1'b1 || bus.pix_data !== data_of(11'h200)) begin n_fail++; $display("FAIL ring_resume_pixel got v=%b d=%h want v=1 d=%h", bus.pix_valid, bus.pix_data, data_of(11'h200)); end
    bus.ring_mode = 1'b0;
  endtask

  task automatic test_priority();
    logic [8:0] exp_x [3];
    exp_x = '{9'd0, 9'd0, 9'd1};
    pulse_field();
    bus.fetch_next = 1'b1;
    bus.next_line  = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL line_drops_fetch got %b want 0", bus.pix_valid); end
    bus.fetch_next = 1'b0;
    @(negedge clk);
    bus.next_line  = 1'b0;
    n_cmp++; if (bus.curr_src_row !== 2'd1) begin n_fail++; $display("FAIL prio_setup_row got %0d want 1", bus.curr_src_row); end
    bus.fetch_next = 1'b1;
    repeat (5) @(negedge clk);
    bus.next_field = 1'b1;
    bus.next_line  = 1'b1;
    @(negedge clk);
    bus.next_field = 1'b0;
    bus.next_line  = 1'b0;
    n_cmp++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL field_line_fetch_no_pixel got %b want 0", bus.pix_valid); end
    n_cmp++; if (bus.curr_src_row !== 2'd0) begin n_fail++; $display("FAIL field_line_row got %0d want 0", bus.curr_src_row); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.pix_data !== data_of({2'd0, exp_x[i]})) begin n_fail++; $display("FAIL post_field_x[%0d] got %h want %h", i, bus.pix_data, data_of({2'd0, exp_x[i]})); end
    end
    bus.fetch_next = 1'b0;
  endtask

  task automatic test_saturation();
    pulse_field();
    bus.fetch_next = 1'b1;
    for (int k = 0; k < 643; k++) begin
      @(negedge clk);
      if (k >= 639) begin
        n_cmp++; if (bus.pix_valid !== 1'b1 || bus.pix_data !== data_of(11'd479)) begin n_fail++; $display("FAIL x_saturate[%0d] got v=%b d=%h want v=1 d=%h", k, bus.pix_valid, bus.pix_data, data_of(11'd479)); end
      end
    end
    bus.fetch_next = 1'b0;
  endtask

  task automatic test_write_collide();
    pulse_field();
    bus.cpu_addr   = 11'd0;
    bus.cpu_wdata  = 24'hABCDEF;
    bus.cpu_wen    = 1'b1;
    bus.fetch_next = 1'b1;
    @(negedge clk);
    bus.cpu_wen    = 1'b0;
    n_cmp++; if (bus.pix_data !== data_of(11'd0)) begin n_fail++; $display("FAIL collide_pix_old got %h want %h", bus.pix_data, data_of(11'd0)); end
    n_cmp++; if (bus.cpu_rdata !== data_of(11'd0)) begin n_fail++; $display("FAIL collide_cpu_old got %h want %h", bus.cpu_rdata, data_of(11'd0)); end
    @(negedge clk);
    bus.fetch_next = 1'b0;
    n_cmp++; if (bus.pix_data !== 24'hABCDEF) begin n_fail++; $display("FAIL collide_pix_new got %h want abcdef", bus.pix_data); end
    n_cmp++; if (bus.cpu_rdata !== 24'hABCDEF) begin n_fail++; $display("FAIL collide_cpu_new got %h want abcdef", bus.cpu_rdata); end
  endtask

  task automatic test_reset_mid_field();
    pulse_field();
    pulse_line();
    pulse_line();
    bus.fetch_next = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.pix_valid !== 1'b0 || bus.pix_data !== 24'h0) begin n_fail++; $display("FAIL midreset_pixel got v=%b d=%h want v=0 d=0", bus.pix_valid, bus.pix_data); end
    n_cmp++; if (bus.curr_src_row !== 2'd0 || bus.state_dbg !== 2'd0) begin n_fail++; $display("FAIL midreset_state got row=%0d st=%0d want 0 0", bus.curr_src_row, bus.state_dbg); end
    n_cmp++; if (bus.cpu_rdata !== 24'h0 || bus.field_done !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs got rd=%h fd=%b want 0 0", bus.cpu_rdata, bus.field_done); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.fetch_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready got %b want 0", bus.fetch_ready); end
    @(negedge clk);
    n_cmp++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_no_fetch got %b want 0", bus.pix_valid); end
    bus.fetch_next = 1'b0;
    pulse_field();
    n_cmp++; if (bus.fetch_ready !== 1'b1) begin n_fail++; $display("FAIL refield_ready got %b want 1", bus.fetch_ready); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.cpu_wen    = 1'b0;
    bus.ring_mode  = 1'b0;
    bus.prod_row   = '0;
    bus.next_field = 1'b0;
    bus.next_line  = 1'b0;
    bus.fetch_next = 1'b0;
    @(negedge clk);
    test_reset();
    test_cpu_port();
    test_x_sequence();
    test_rows();
    test_ring_stall();
    test_priority();
    test_saturation();
    test_write_collide();
    test_reset_mid_field();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
